// File: rtl/destruct_stream_gbox.sv
// Wide-to-narrow stream gearbox: ISIZE-bit beats in, OSIZE-bit words out,
// MSB slice first. A residue buffer carries leftover bits across input
// beats, and an end-of-line flush emits the partial final word with a byte mask.
module destruct_stream_gbox #(
  parameter int ISIZE = 256,
  parameter int OSIZE = 24
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ialign,
  input  logic               ivalid,
  output logic               iready,
  input  logic [ISIZE-1:0]   idata,
  input  logic               ilast,
  output logic               ovalid,
  input  logic               oready,
  output logic [OSIZE-1:0]   odata,
  output logic               olast,
  output logic [OSIZE/8-1:0] omask
);

  localparam int BW = ISIZE + 2*OSIZE;
  localparam int CW = $clog2(BW + 1);
  localparam int OB = OSIZE / 8;

  localparam logic [CW-1:0] OSZ  = CW'(OSIZE);
  localparam logic [CW-1:0] OSZ2 = CW'(2*OSIZE);
  localparam logic [CW-1:0] ISZ  = CW'(ISIZE);
  // Write window for a new beat, MSB-aligned before shifting down by cnt
  localparam logic [BW-1:0] WIN  = {{ISIZE{1'b1}}, {(2*OSIZE){1'b0}}};
  localparam logic [OB-1:0] ONES = '1;

  logic [BW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  logic          ofire, ifire;
  logic [CW-1:0] cnt_rem;
  logic [BW-1:0] buf_sh;

  assign odata = data_q[BW-1 -: OSIZE];

  // Handshake and word qualifiers, all decoded from registered state
  always_comb begin
    ovalid = ~ialign & ((cnt_q >= OSZ) | (last_q & (cnt_q != '0)));
    iready = ~ialign & ~last_q & (cnt_q < OSZ2);
    olast  = ovalid & last_q & (cnt_q <= OSZ);
    omask  = '0;
    if (ovalid) begin
      omask = (cnt_q >= OSZ) ? ONES : ~(ONES >> cnt_q[CW-1:3]);
    end
  end

  // Next state: drain the output word first, then append the accepted beat
  // directly below whatever residue remains after the drain
  always_comb begin
    ofire   = ovalid & oready;
    ifire   = ivalid & iready;
    cnt_rem = cnt_q;
    buf_sh  = data_q;
    if (ofire) begin
      cnt_rem = (cnt_q >= OSZ) ? (cnt_q - OSZ) : '0;
      buf_sh  = data_q << OSIZE;
    end
    data_d = buf_sh;
    cnt_d  = cnt_rem;
    last_d = last_q;
    if (ifire) begin
      data_d = (buf_sh & ~(WIN >> cnt_rem)) |
               ({idata, {(2*OSIZE){1'b0}}} >> cnt_rem);
      cnt_d  = cnt_rem + ISZ;
      if (ilast) last_d = 1'b1;
    end
    if (ofire && olast) last_d = 1'b0;
    if (ialign) begin
      cnt_d  = '0;
      last_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_destruct_stream_gbox.sv
// Self-checking bench for destruct_stream_gbox using a byte-queue reference model.
module tb_destruct_stream_gbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, ialign, ivalid, ilast, oready;
  logic [255:0] idata;
  logic         iready, ovalid, olast;
  logic [23:0]  odata;
  logic [2:0]   omask;

  logic         b_ivalid, b_ilast, b_oready;
  logic [127:0] b_idata;
  logic         b_iready, b_ovalid, b_olast;
  logic [31:0]  b_odata;
  logic [3:0]   b_omask;

  destruct_stream_gbox #(.ISIZE(256), .OSIZE(24)) dut (
    .clock(clk), .rst_n(rst_n), .ialign(ialign), .ivalid(ivalid), .iready(iready),
    .idata(idata), .ilast(ilast), .ovalid(ovalid), .oready(oready), .odata(odata),
    .olast(olast), .omask(omask)
  );

  destruct_stream_gbox #(.ISIZE(128), .OSIZE(32)) dut_b (
    .clock(clk), .rst_n(rst_n), .ialign(1'b0), .ivalid(b_ivalid), .iready(b_iready),
    .idata(b_idata), .ilast(b_ilast), .ovalid(b_ovalid), .oready(b_oready), .odata(b_odata),
    .olast(b_olast), .omask(b_omask)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the stream as a queue of bytes, MSB byte first
  logic [7:0]   mq[$];
  bit           mlast;
  logic [255:0] pend_d[$];
  bit           pend_l[$];
  int unsigned  ivp, orp;
  logic [23:0]  wd[$];
  logic [2:0]   wm[$];
  bit           wl[$];
  int           wc[$];
  int           cyc;
  bit           stall_prev;
  logic [23:0]  pd;
  logic [2:0]   pm;
  logic         pl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ivalid = (pend_d.size() > 0) && ($urandom_range(0, 99) < ivp);
    idata  = (pend_d.size() > 0) ? pend_d[0] : '0;
    ilast  = (pend_l.size() > 0) ? pend_l[0] : 1'b0;
    oready = $urandom_range(0, 99) < orp;
  endtask

  task automatic clear_log();
    wd.delete(); wm.delete(); wl.delete(); wc.delete();
  endtask

  task automatic cycle();
    int n;
    logic [23:0] ew, mk;
    logic [2:0]  em;
    logic        el, eov, eir, of, inf;
    @(negedge clk);
    eov = !ialign && (mq.size() >= 3 || (mlast && mq.size() > 0));
    eir = !ialign && !mlast && mq.size() < 6;
    check("ovalid", 64'(ovalid), 64'(eov));
    check("iready", 64'(iready), 64'(eir));
    if (eov) begin
      n  = (mq.size() >= 3) ? 3 : mq.size();
      ew = '0; mk = '0; em = '0;
      for (int i = 0; i < n; i++) begin
        ew[23-8*i -: 8] = mq[i];
        mk[23-8*i -: 8] = 8'hFF;
        em[2-i] = 1'b1;
      end
      el = mlast && mq.size() <= 3;
      check("odata", 64'(odata & mk), 64'(ew));
      check("omask", 64'(omask), 64'(em));
      check("olast", 64'(olast), 64'(el));
    end else begin
      check("omask_idle", 64'(omask), 64'(0));
      check("olast_idle", 64'(olast), 64'(0));
    end
    if (stall_prev && !ialign) begin
      check("hold_ovalid", 64'(ovalid), 64'(1));
      check("hold_odata", 64'(odata), 64'(pd));
      check("hold_omask", 64'(omask), 64'(pm));
      check("hold_olast", 64'(olast), 64'(pl));
    end
    stall_prev = ovalid && !oready;
    pd = odata; pm = omask; pl = olast;
    of  = ovalid && oready;
    inf = ivalid && iready;
    if (of) begin
      wd.push_back(odata); wm.push_back(omask); wl.push_back(olast); wc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (ialign) begin
      mq.delete();
      mlast = 1'b0;
    end else begin
      if (of) begin
        for (int i = 0; i < 3 && mq.size() > 0; i++) void'(mq.pop_front());
        if (mlast && mq.size() == 0) mlast = 1'b0;
      end
      if (inf) begin
        for (int k = 31; k >= 0; k--) mq.push_back(idata[8*k +: 8]);
        if (ilast) mlast = 1'b1;
        void'(pend_d.pop_front());
        void'(pend_l.pop_front());
      end
    end
    #1;
    drive();
  endtask

  task automatic run_drain(input int lim);
    int k = 0;
    while (!(pend_d.size() == 0 && mq.size() == 0 && !mlast) && k < lim) begin
      cycle();
      k++;
    end
    check("drain_in_time", 64'(k < lim), 64'(1));
  endtask

  task automatic run_words(input int n, input int lim);
    int k = 0;
    while (wd.size() < n && k < lim) begin
      cycle();
      k++;
    end
    check("words_in_time", 64'(k < lim), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] beat;
    logic [127:0] bd[2];
    logic [31:0]  bw[$];
    logic [3:0]   bm[$];
    bit           bl[$];
    int           nl, bi;
    logic         bin;

    rst_n = 1'b0; ialign = 1'b0; ivalid = 1'b0; ilast = 1'b0; oready = 1'b0; idata = '0;
    b_ivalid = 1'b0; b_ilast = 1'b0; b_oready = 1'b0; b_idata = '0;
    ivp = 100; orp = 100; cyc = 0; stall_prev = 1'b0; mlast = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_iready", 64'(iready), 64'(1));
    check("rst_ovalid", 64'(ovalid), 64'(0));
    check("rst_olast", 64'(olast), 64'(0));
    check("rst_omask", 64'(omask), 64'(0));
    check("rst_odata", 64'(odata), 64'(0));
    @(posedge clk); #1;

    // One beat, byte k = k, ilast set, oready always high
    clear_log();
    for (int k = 0; k < 32; k++) beat[8*k +: 8] = 8'(k);
    pend_d.push_back(beat); pend_l.push_back(1'b1);
    drive();
    run_drain(100);
    check("b1_count", 64'(wd.size()), 64'(11));
    if (wd.size() == 11) begin
      check("b1_word0", 64'(wd[0]), 64'(24'h1F1E1D));
      check("b1_mask0", 64'(wm[0]), 64'(3'b111));
      check("b1_mask9", 64'(wm[9]), 64'(3'b111));
      check("b1_mask10", 64'(wm[10]), 64'(3'b110));
      check("b1_data10", 64'(wd[10][23:8]), 64'(16'h0100));
      check("b1_last10", 64'(wl[10]), 64'(1));
      check("b1_last9", 64'(wl[9]), 64'(0));
    end

    // Three back-to-back beats: 32 words with no gaps
    clear_log();
    for (int b = 0; b < 3; b++) begin
      pend_d.push_back({8{$urandom()}});
      pend_l.push_back(b == 2);
    end
    drive();
    run_drain(200);
    check("bb_count", 64'(wd.size()), 64'(32));
    if (wd.size() == 32) begin
      check("bb_nogap", 64'(wc[31] - wc[0]), 64'(31));
      nl = 0;
      foreach (wl[i]) nl += int'(wl[i]);
      check("bb_nlast", 64'(nl), 64'(1));
      check("bb_last31", 64'(wl[31]), 64'(1));
    end

    // Randomised traffic with back-pressure and random line ends
    ivp = 75; orp = 50;
    for (int b = 0; b < 20; b++) begin
      pend_d.push_back({8{$urandom()}});
      pend_l.push_back((b == 19) || ($urandom_range(0, 3) == 0));
    end
    drive();
    run_drain(3000);
    ivp = 100; orp = 100;

    // ialign after 5 words of a beat, then a fresh beat
    clear_log();
    pend_d.push_back({8{$urandom()}}); pend_l.push_back(1'b0);
    drive();
    run_words(5, 50);
    ialign = 1'b1;
    cycle();
    ialign = 1'b0;
    clear_log();
    beat = {8{$urandom()}};
    pend_d.push_back(beat); pend_l.push_back(1'b1);
    drive();
    run_drain(100);
    if (wd.size() > 0) check("align_first", 64'(wd[0]), 64'(beat[255:232]));
    else check("align_words", 64'(wd.size()), 64'(11));

    // Asynchronous reset mid-stream
    clear_log();
    pend_d.push_back({8{$urandom()}}); pend_l.push_back(1'b0);
    drive();
    run_words(2, 50);
    rst_n = 1'b0;
    #1;
    check("arst_iready", 64'(iready), 64'(1));
    check("arst_ovalid", 64'(ovalid), 64'(0));
    check("arst_omask", 64'(omask), 64'(0));
    check("arst_odata", 64'(odata), 64'(0));
    mq.delete(); mlast = 1'b0; pend_d.delete(); pend_l.delete(); stall_prev = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    beat = {8{$urandom()}};
    pend_d.push_back(beat); pend_l.push_back(1'b1);
    drive();
    run_drain(100);
    if (wd.size() > 0) check("arst_first", 64'(wd[0]), 64'(beat[255:232]));
    else check("arst_words", 64'(wd.size()), 64'(11));

    // 128/32 instance: two beats, exactly four full words each
    bd[0] = {4{$urandom()}};
    bd[1] = {4{$urandom()}};
    bi = 0;
    b_ivalid = 1'b1; b_idata = bd[0]; b_ilast = 1'b0; b_oready = 1'b1;
    for (int k = 0; k < 40 && bw.size() < 8; k++) begin
      @(negedge clk);
      bin = b_ivalid && b_iready;
      if (b_ovalid && b_oready) begin
        bw.push_back(b_odata); bm.push_back(b_omask); bl.push_back(b_olast);
      end
      @(posedge clk); #1;
      if (bin) begin
        bi++;
        if (bi < 2) begin
          b_idata = bd[bi];
          b_ilast = 1'b1;
        end else begin
          b_ivalid = 1'b0;
        end
      end
    end
    check("i2_count", 64'(bw.size()), 64'(8));
    for (int j = 0; j < 8 && j < bw.size(); j++) begin
      logic [127:0] t;
      t = bd[j/4];
      check($sformatf("i2_word%0d", j), 64'(bw[j]), 64'(t[127-32*(j%4) -: 32]));
      check($sformatf("i2_mask%0d", j), 64'(bm[j]), 64'(4'b1111));
      check($sformatf("i2_last%0d", j), 64'(bl[j]), 64'(j == 7));
    end
    @(negedge clk);
    check("i2_idle", 64'(b_ovalid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
